// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : decoder_rr_arbiter
// Brief    : Round-robin arbiter that shares one 2-to-4 decoder among four
//            requesters, with break-before-make between owners.
//            Optional hold limit compiled in with macro ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       en_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [1:0] w_win;
    logic [3:0] r_gnt;
    logic       r_en_n;
    logic       r_busy;
    logic       w_any;
    logic       w_expire;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("decoder_rr_arbiter: HOLD_MAX must be in 1..255");
    end

    assign w_any = |req;

    // Scan offsets high to low so the offset closest to ptr is assigned last.
    always_comb begin
        w_win = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win = r_ptr + 2'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);

    logic [7:0] r_hold_cnt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    assign w_expire      = (r_hold_cnt == c_hold_last);
    assign w_timeout_nxt = (r_state == ST_GRANT) && req[r_sel] && w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
            if (r_state == ST_GRANT && w_state_nxt == ST_GRANT) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end else begin
                r_hold_cnt <= 8'd0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_ptr_nxt   = w_win + 2'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[r_sel] || w_expire) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are derived from next-state so they are registered yet aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_en_n  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= (w_state_nxt == ST_GRANT) ? (4'b0001 << w_sel_nxt) : 4'b0000;
            r_en_n  <= (w_state_nxt != ST_GRANT);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign en_n = r_en_n;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_rr_arbiter
// Brief    : Directed self-checking bench for decoder_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

    localparam int c_hold_max = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en_n;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_rr_arbiter #(
        .HOLD_MAX (c_hold_max)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .en_n    (en_n),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("onehot", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                             input logic e_en_n, input logic e_busy);
        check({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
        check({tag, ".sel"},  32'(sel),  32'(e_sel));
        check({tag, ".en_n"}, 32'(en_n), 32'(e_en_n));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_out("rst", 4'b0000, 2'b00, 1'b1, 1'b0);
        check("rst.timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Reset asserted mid-grant clears outputs without a clock edge.
        req = 4'b0100;
        step();
        check_out("pre_rst", 4'b0100, 2'b10, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 4'b0000, 2'b00, 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        step();
        check_out("post_rst", 4'b0100, 2'b10, 1'b0, 1'b1);
        req = 4'b0000;
        step();
        check_out("post_rst_rel", 4'b0000, 2'b10, 1'b1, 1'b1);
        step();
        check_out("post_rst_idle", 4'b0000, 2'b10, 1'b1, 1'b0);

        // Single requester, ptr=3 here so search 3,0 picks 0.
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("single_hold", 4'b0001, 2'b00, 1'b0, 1'b1);
        end
        req = 4'b0000;
        step();
        check_out("single_rel", 4'b0000, 2'b00, 1'b1, 1'b1);
        step();
        check_out("single_idle", 4'b0000, 2'b00, 1'b1, 1'b0);

        // Round-robin from ptr=0, each owner holds two cycles.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] k;
            k = 2'(i % 4);
            step();
            check_out("rr_g1", 4'b0001 << k, k, 1'b0, 1'b1);
            step();
            check_out("rr_g2", 4'b0001 << k, k, 1'b0, 1'b1);
            req = 4'b1111 & ~(4'b0001 << k);
            step();
            check_out("rr_gap", 4'b0000, k, 1'b1, 1'b1);
            req = (i < 4) ? 4'b1111 : 4'b0000;
        end
        step();
        check_out("rr_idle", 4'b0000, 2'b00, 1'b1, 1'b0);

        // ptr=1: idx 3 wins, idx 1 must not preempt, then ptr wraps to 0.
        req = 4'b1000;
        step();
        check_out("wrap_g3", 4'b1000, 2'b11, 1'b0, 1'b1);
        req = 4'b1010;
        step();
        check_out("nopre_1", 4'b1000, 2'b11, 1'b0, 1'b1);
        step();
        check_out("nopre_2", 4'b1000, 2'b11, 1'b0, 1'b1);
        req = 4'b0010;
        step();
        check_out("wrap_gap", 4'b0000, 2'b11, 1'b1, 1'b1);
        step();
        check_out("wrap_g1", 4'b0010, 2'b01, 1'b0, 1'b1);
        req = 4'b0000;
        step();
        step();
        check_out("wrap_idle", 4'b0000, 2'b01, 1'b1, 1'b0);

        // Hold limit behaviour with two competing requesters.
        do_reset();
        req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < c_hold_max; i++) begin
            step();
            check_out("to_g0", 4'b0001, 2'b00, 1'b0, 1'b1);
            check("to_g0.timeout", 32'(timeout), 32'd0);
        end
        step();
        check_out("to_rel0", 4'b0000, 2'b00, 1'b1, 1'b1);
        check("to_rel0.timeout", 32'(timeout), 32'd1);
        for (int i = 0; i < c_hold_max; i++) begin
            step();
            check_out("to_g1", 4'b0010, 2'b01, 1'b0, 1'b1);
            check("to_g1.timeout", 32'(timeout), 32'd0);
        end
        step();
        check_out("to_rel1", 4'b0000, 2'b01, 1'b1, 1'b1);
        check("to_rel1.timeout", 32'(timeout), 32'd1);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check_out("nto_g0", 4'b0001, 2'b00, 1'b0, 1'b1);
            check("nto_g0.timeout", 32'(timeout), 32'd0);
        end
`endif
        req = 4'b0000;
        repeat (3) step();
        check_out("end_idle", 4'b0000, gnt == 4'b0000 ? sel : 2'b00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
